// File: rtl/jedro_1_core.sv
// Minimal 3-stage in-order RV32I core (fetch, decode/execute, writeback).
// Integer ALU subset only (OP, OP-IMM, LUI); anything else halts the core.
package jedro_1_pkg;
  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_LUI
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
endpackage

module jedro_1_core_regfile #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  i_we,
  input  logic [4:0]            i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [4:0]            i_raddr_a,
  input  logic [4:0]            i_raddr_b,
  output logic [DATA_WIDTH-1:0] o_rdata_a,
  output logic [DATA_WIDTH-1:0] o_rdata_b
);
  logic [DATA_WIDTH-1:0] regfile [0:31];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < 32; i++) regfile[i] <= '0;
    end else if (i_we && (i_waddr != 5'd0)) begin
      regfile[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == 5'd0) ? '0 : regfile[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == 5'd0) ? '0 : regfile[i_raddr_b];
endmodule

module jedro_1_core_decoder #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  i_valid,
  input  logic [31:0]           i_instr,
  output logic [4:0]            o_rs1,
  output logic [4:0]            o_rs2,
  output logic [4:0]            o_rd,
  output jedro_1_pkg::alu_op_e  o_alu_op,
  output logic                  o_use_imm,
  output logic [DATA_WIDTH-1:0] o_imm,
  output logic                  o_illegal,
  output logic                  illegal_instr_ro
);
  import jedro_1_pkg::*;

  logic [6:0] w_opcode;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_bad;

  assign w_opcode = i_instr[6:0];
  assign w_f3     = i_instr[14:12];
  assign w_f7     = i_instr[31:25];
  assign o_rs1    = i_instr[19:15];
  assign o_rs2    = i_instr[24:20];
  assign o_rd     = i_instr[11:7];

  always_comb begin
    o_alu_op  = ALU_ADD;
    o_use_imm = 1'b0;
    o_imm     = {{(DATA_WIDTH-12){i_instr[31]}}, i_instr[31:20]};
    w_bad     = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        if (w_f7 == F7_BASE) begin
          case (w_f3)
            3'd0: o_alu_op = ALU_ADD;
            3'd1: o_alu_op = ALU_SLL;
            3'd2: o_alu_op = ALU_SLT;
            3'd3: o_alu_op = ALU_SLTU;
            3'd4: o_alu_op = ALU_XOR;
            3'd5: o_alu_op = ALU_SRL;
            3'd6: o_alu_op = ALU_OR;
            3'd7: o_alu_op = ALU_AND;
          endcase
        end else if ((w_f7 == F7_ALT) && (w_f3 == 3'd0)) begin
          o_alu_op = ALU_SUB;
        end else if ((w_f7 == F7_ALT) && (w_f3 == 3'd5)) begin
          o_alu_op = ALU_SRA;
        end else begin
          w_bad = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        o_use_imm = 1'b1;
        case (w_f3)
          3'd0: o_alu_op = ALU_ADD;
          3'd2: o_alu_op = ALU_SLT;
          3'd3: o_alu_op = ALU_SLTU;
          3'd4: o_alu_op = ALU_XOR;
          3'd6: o_alu_op = ALU_OR;
          3'd7: o_alu_op = ALU_AND;
          3'd1: begin
            o_alu_op = ALU_SLL;
            w_bad    = (w_f7 != F7_BASE);
          end
          3'd5: begin
            if (w_f7 == F7_BASE)     o_alu_op = ALU_SRL;
            else if (w_f7 == F7_ALT) o_alu_op = ALU_SRA;
            else                     w_bad    = 1'b1;
          end
        endcase
      end
      OPC_LUI: begin
        o_use_imm = 1'b1;
        o_alu_op  = ALU_LUI;
        o_imm     = {i_instr[31:12], 12'b0};
      end
      default: w_bad = 1'b1;
    endcase
  end

  assign o_illegal = i_valid & w_bad;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)        illegal_instr_ro <= 1'b0;
    else if (o_illegal) illegal_instr_ro <= 1'b1;
  end
endmodule

module jedro_1_core #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  output logic [ADDR_WIDTH-1:0] iram_addr,
  input  logic [31:0]           iram_rdata,
  output logic [3:0]            dram_we,
  output logic                  dram_stb,
  output logic [ADDR_WIDTH-1:0] dram_addr,
  output logic [DATA_WIDTH-1:0] dram_wdata,
  input  logic [DATA_WIDTH-1:0] dram_rdata,
  input  logic                  dram_ack,
  input  logic                  dram_err
);
  import jedro_1_pkg::*;

  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_dec_valid;
  logic                  r_wb_valid;
  logic [4:0]            r_wb_rd;
  logic [DATA_WIDTH-1:0] r_wb_result;

  logic                  w_issue;
  logic [4:0]            w_rs1, w_rs2, w_rd;
  alu_op_e               w_alu_op;
  logic                  w_use_imm;
  logic [DATA_WIDTH-1:0] w_imm;
  logic                  w_dec_illegal;
  logic                  w_halted;
  logic [DATA_WIDTH-1:0] w_rf_a, w_rf_b;
  logic [DATA_WIDTH-1:0] w_op_a, w_op_b;
  logic [4:0]            w_shamt;
  logic [DATA_WIDTH-1:0] w_alu_res;
  logic                  w_unused_dram;

  assign w_issue = r_dec_valid & ~w_halted;

  jedro_1_core_decoder #(.DATA_WIDTH(DATA_WIDTH)) decoder_inst (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .i_valid          (w_issue),
    .i_instr          (iram_rdata),
    .o_rs1            (w_rs1),
    .o_rs2            (w_rs2),
    .o_rd             (w_rd),
    .o_alu_op         (w_alu_op),
    .o_use_imm        (w_use_imm),
    .o_imm            (w_imm),
    .o_illegal        (w_dec_illegal),
    .illegal_instr_ro (w_halted)
  );

  jedro_1_core_regfile #(.DATA_WIDTH(DATA_WIDTH)) regfile_inst (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .i_we      (r_wb_valid),
    .i_waddr   (r_wb_rd),
    .i_wdata   (r_wb_result),
    .i_raddr_a (w_rs1),
    .i_raddr_b (w_rs2),
    .o_rdata_a (w_rf_a),
    .o_rdata_b (w_rf_b)
  );

  // The writeback result lands in the regfile on this same edge, so forward it.
  assign w_op_a = (r_wb_valid && (r_wb_rd == w_rs1) && (w_rs1 != 5'd0)) ? r_wb_result : w_rf_a;
  assign w_op_b = w_use_imm ? w_imm :
                  (r_wb_valid && (r_wb_rd == w_rs2) && (w_rs2 != 5'd0)) ? r_wb_result : w_rf_b;
  assign w_shamt = w_op_b[4:0];

  always_comb begin
    w_alu_res = '0;
    case (w_alu_op)
      ALU_ADD:  w_alu_res = w_op_a + w_op_b;
      ALU_SUB:  w_alu_res = w_op_a - w_op_b;
      ALU_SLL:  w_alu_res = w_op_a << w_shamt;
      ALU_SLT:  w_alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
      ALU_SLTU: w_alu_res = {{(DATA_WIDTH-1){1'b0}}, (w_op_a < w_op_b)};
      ALU_XOR:  w_alu_res = w_op_a ^ w_op_b;
      ALU_SRL:  w_alu_res = w_op_a >> w_shamt;
      ALU_SRA:  w_alu_res = DATA_WIDTH'($signed(w_op_a) >>> w_shamt);
      ALU_OR:   w_alu_res = w_op_a | w_op_b;
      ALU_AND:  w_alu_res = w_op_a & w_op_b;
      ALU_LUI:  w_alu_res = w_op_b;
      default:  w_alu_res = '0;
    endcase
  end

  // PC stops on the same edge that latches the illegal flag.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_pc        <= BOOT_ADDR;
      r_dec_valid <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= 5'd0;
      r_wb_result <= '0;
    end else begin
      r_dec_valid <= 1'b1;
      if (!(w_halted || w_dec_illegal)) r_pc <= r_pc + ADDR_WIDTH'(4);
      r_wb_valid  <= w_issue & ~w_dec_illegal;
      r_wb_rd     <= w_rd;
      r_wb_result <= w_alu_res;
    end
  end

  assign iram_addr  = r_pc;
  assign dram_we    = 4'b0000;
  assign dram_stb   = 1'b0;
  assign dram_addr  = '0;
  assign dram_wdata = '0;

  assign w_unused_dram = ^{dram_rdata, dram_ack, dram_err};
endmodule

// File: tb/tb_jedro_1_core.sv
// Bench for jedro_1_core: directed and random programs in a ROM, compared
// against an instruction-level ISA model of the supported RV32I subset.
module tb_jedro_1_core;
  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic [31:0] iram_addr;
  logic [31:0] iram_rdata;
  logic [3:0]  dram_we;
  logic        dram_stb;
  logic [31:0] dram_addr;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata = '0;
  logic        dram_ack = 1'b0;
  logic        dram_err = 1'b0;

  int checks = 0;
  int errors = 0;
  logic        dram_bad = 1'b0;
  logic [31:0] rom  [0:63];
  logic [31:0] mreg [0:31];
  int          plen;
  logic [9:0]  r_ops [0:9] = '{10'h000, 10'h100, 10'h001, 10'h002, 10'h003,
                               10'h004, 10'h005, 10'h105, 10'h006, 10'h007};

  jedro_1_core dut (
    .clk_i      (clk),
    .rstn_i     (rstn_i),
    .iram_addr  (iram_addr),
    .iram_rdata (iram_rdata),
    .dram_we    (dram_we),
    .dram_stb   (dram_stb),
    .dram_addr  (dram_addr),
    .dram_wdata (dram_wdata),
    .dram_rdata (dram_rdata),
    .dram_ack   (dram_ack),
    .dram_err   (dram_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) iram_rdata <= rom[iram_addr[7:2]];

  always @(negedge clk)
    if (dram_we !== 4'b0 || dram_stb !== 1'b0 || dram_addr !== 32'b0 || dram_wdata !== 32'b0)
      dram_bad = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] lui_ins(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    plen = 0;
  endtask

  task automatic put(input logic [31:0] w);
    rom[plen] = w;
    plen++;
  endtask

  // Architectural reference: executes one instruction on mreg.
  task automatic model_step(input logic [31:0] ins, output bit bad);
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b, imm, res;
    rd = ins[11:7]; rs1 = ins[19:15]; rs2 = ins[24:20];
    f3 = ins[14:12]; f7 = ins[31:25];
    a = mreg[rs1]; b = mreg[rs2];
    imm = {{20{ins[31]}}, ins[31:20]};
    bad = 1'b0;
    res = 32'h0;
    case (ins[6:0])
      7'b0110011: begin
        case ({f7, f3})
          10'h000: res = a + b;
          10'h100: res = a - b;
          10'h001: res = a << b[4:0];
          10'h002: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          10'h003: res = (a < b) ? 32'd1 : 32'd0;
          10'h004: res = a ^ b;
          10'h005: res = a >> b[4:0];
          10'h105: res = $signed(a) >>> b[4:0];
          10'h006: res = a | b;
          10'h007: res = a & b;
          default: bad = 1'b1;
        endcase
      end
      7'b0010011: begin
        case (f3)
          3'd0: res = a + imm;
          3'd2: res = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
          3'd3: res = (a < imm) ? 32'd1 : 32'd0;
          3'd4: res = a ^ imm;
          3'd6: res = a | imm;
          3'd7: res = a & imm;
          3'd1: if (f7 == 7'h00) res = a << ins[24:20]; else bad = 1'b1;
          3'd5: begin
            if (f7 == 7'h00)      res = a >> ins[24:20];
            else if (f7 == 7'h20) res = $signed(a) >>> ins[24:20];
            else                  bad = 1'b1;
          end
        endcase
      end
      7'b0110111: res = {ins[31:12], 12'h000};
      default: bad = 1'b1;
    endcase
    if (!bad && rd != 5'd0) mreg[rd] = res;
  endtask

  task automatic model_run(output int k);
    bit bad;
    for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
    k = 63;
    for (int i = 0; i < 64; i++) begin
      model_step(rom[i], bad);
      if (bad) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn_i = 1'b0;
    dram_rdata = $urandom;
    dram_ack = 1'($urandom_range(0, 1));
    dram_err = 1'($urandom_range(0, 1));
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 32; i++)
      check($sformatf("%s x%0d", tag, i), dut.regfile_inst.regfile[i], mreg[i]);
  endtask

  task automatic run_to_halt(input string tag, input int k);
    int cyc = 0;
    while (dut.decoder_inst.illegal_instr_ro !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " halt"}, {31'b0, dut.decoder_inst.illegal_instr_ro}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check({tag, " pc"}, iram_addr, 32'((k + 1) * 4));
    check_regs(tag);
    repeat (4) @(posedge clk);
    #1;
    check({tag, " pc frozen"}, iram_addr, 32'((k + 1) * 4));
  endtask

  task automatic gen_random_prog();
    int n;
    logic [4:0]  rd, rs1, rs2, sh;
    logic [2:0]  f3;
    logic [9:0]  op;
    logic [31:0] r;
    clear_rom();
    n = $urandom_range(8, 40);
    for (int i = 0; i < n; i++) begin
      rd  = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      r   = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: begin
          op = r_ops[$urandom_range(0, 9)];
          put(r_ins(op[9:3], rs2, rs1, op[2:0], rd));
        end
        9: put(lui_ins(r[19:0], rd));
        default: begin
          f3 = 3'($urandom_range(0, 7));
          sh = r[4:0];
          if (f3 == 3'd1)      put(i_ins({7'h00, sh}, rs1, f3, rd));
          else if (f3 == 3'd5) put(i_ins({r[31] ? 7'h20 : 7'h00, sh}, rs1, f3, rd));
          else                 put(i_ins(r[11:0], rs1, f3, rd));
        end
      endcase
    end
    case ($urandom_range(0, 3))
      0: put(32'h0);
      1: put({12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011});
      2: put(r_ins(7'h01, 5'd2, 5'd1, 3'd0, 5'd3));
      default: put(i_ins({7'h20, 5'd3}, 5'd1, 3'd1, 5'd2));
    endcase
  endtask

  initial begin
    int k;
    // Step 1: reset state and first-result latency on the dependency chain.
    clear_rom();
    put(i_ins(12'd2, 5'd0, 3'd0, 5'd1));
    put(r_ins(7'h00, 5'd0, 5'd1, 3'd0, 5'd2));
    put(r_ins(7'h00, 5'd2, 5'd0, 3'd0, 5'd3));
    put(r_ins(7'h00, 5'd0, 5'd3, 3'd0, 5'd4));
    put(i_ins(12'd1, 5'd0, 3'd0, 5'd5));
    put(r_ins(7'h00, 5'd5, 5'd4, 3'd0, 5'd10));
    put(32'h0);
    model_run(k);
    repeat (2) @(negedge clk);
    #1;
    check("reset pc", iram_addr, 32'h0);
    check("reset flag", {31'b0, dut.decoder_inst.illegal_instr_ro}, 32'd0);
    for (int i = 0; i < 32; i++)
      check($sformatf("reset x%0d", i), dut.regfile_inst.regfile[i], 32'h0);
    @(negedge clk);
    rstn_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("latency x1 early", dut.regfile_inst.regfile[1], 32'd0);
    @(posedge clk);
    #1;
    check("latency x1", dut.regfile_inst.regfile[1], 32'd2);
    run_to_halt("p1", k);
    check("p1 k", 32'(k), 32'd6);
    check("p1 x4", dut.regfile_inst.regfile[4], 32'd2);
    check("p1 x10", dut.regfile_inst.regfile[10], 32'd3);

    // Step 2: signed/unsigned compare and subtract wrap.
    clear_rom();
    put(i_ins(12'hFFF, 5'd0, 3'd0, 5'd1));
    put(r_ins(7'h00, 5'd1, 5'd0, 3'd3, 5'd2));
    put(r_ins(7'h00, 5'd0, 5'd1, 3'd2, 5'd3));
    put(r_ins(7'h20, 5'd1, 5'd0, 3'd0, 5'd4));
    model_run(k);
    do_reset();
    run_to_halt("p2", k);
    check("p2 x1", dut.regfile_inst.regfile[1], 32'hFFFF_FFFF);
    check("p2 x2", dut.regfile_inst.regfile[2], 32'd1);
    check("p2 x3", dut.regfile_inst.regfile[3], 32'd1);
    check("p2 x4", dut.regfile_inst.regfile[4], 32'd1);

    // Step 3: LUI and shifts.
    clear_rom();
    put(lui_ins(20'h12345, 5'd6));
    put(i_ins(12'h678, 5'd6, 3'd6, 5'd6));
    put(i_ins({7'h20, 5'd4}, 5'd6, 3'd5, 5'd7));
    put(i_ins(12'd4, 5'd6, 3'd1, 5'd8));
    model_run(k);
    do_reset();
    run_to_halt("p3", k);
    check("p3 x6", dut.regfile_inst.regfile[6], 32'h1234_5678);
    check("p3 x7", dut.regfile_inst.regfile[7], 32'h0123_4567);
    check("p3 x8", dut.regfile_inst.regfile[8], 32'h2345_6780);

    // Step 4: reset asserted mid-program discards everything in flight.
    do_reset();
    repeat (5) @(posedge clk);
    #2;
    rstn_i = 1'b0;
    #1;
    check("midreset pc", iram_addr, 32'h0);
    for (int i = 0; i < 32; i++)
      check($sformatf("midreset x%0d", i), dut.regfile_inst.regfile[i], 32'h0);
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
    run_to_halt("p3 rerun", k);

    // Step 5: x0 writes are discarded and never forwarded.
    clear_rom();
    put(i_ins(12'd9, 5'd0, 3'd0, 5'd1));
    put(i_ins(12'd5, 5'd0, 3'd0, 5'd0));
    put(r_ins(7'h00, 5'd0, 5'd0, 3'd0, 5'd1));
    model_run(k);
    do_reset();
    run_to_halt("p4", k);
    check("p4 x0", dut.regfile_inst.regfile[0], 32'd0);
    check("p4 x1", dut.regfile_inst.regfile[1], 32'd0);

    // Step 6: a load is illegal and leaves earlier results intact.
    clear_rom();
    put(i_ins(12'd7, 5'd0, 3'd0, 5'd1));
    put(i_ins(12'd9, 5'd0, 3'd0, 5'd2));
    put({12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011});
    put(i_ins(12'd1, 5'd0, 3'd0, 5'd3));
    model_run(k);
    do_reset();
    run_to_halt("p5", k);
    check("p5 x2", dut.regfile_inst.regfile[2], 32'd9);
    check("p5 x3", dut.regfile_inst.regfile[3], 32'd0);
    check("p5 x5", dut.regfile_inst.regfile[5], 32'd0);

    // Step 7: random programs over a small register set.
    for (int p = 0; p < 8; p++) begin
      gen_random_prog();
      model_run(k);
      do_reset();
      run_to_halt($sformatf("rand%0d", p), k);
    end

    check("dram idle", {31'b0, dram_bad}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/jedro_1_core.md
Name: jedro_1_core

Overview:
- Minimal 3-stage in-order RV32I integer core: fetch, decode/execute, writeback.
- Fetches from a synchronous instruction ROM with 1-cycle read latency.
- Executes the integer ALU subset: OP, OP-IMM, LUI. Every other encoding is illegal and halts the core.
- Carries the data-memory bus ports of the full core; they are driven inactive in this revision.

Parameters:
- DATA_WIDTH, 32, register and datapath width (only 32 supported).
- ADDR_WIDTH, 32, instruction/data address width.
- BOOT_ADDR, 32'h0000_0000, first PC after reset.

Ports:
- clk_i  in  1  system clock, all state on rising edge.
- rstn_i  in  1  reset; one clock, reset is asynchronous and active-low.
- iram_addr  out  32  byte address of the instruction to fetch (= PC).
- iram_rdata  in  32  instruction word, valid one cycle after iram_addr.
- dram_we  out  4  byte write enables; constant 0.
- dram_stb  out  1  data request strobe; constant 0.
- dram_addr  out  32  data address; constant 0.
- dram_wdata  out  32  write data; constant 0.
- dram_rdata  in  32  read data; ignored.
- dram_ack  in  1  data acknowledge; ignored.
- dram_err  in  1  data error; ignored.

Behaviour:
- Reset (async, rstn_i=0):
  - PC=BOOT_ADDR, so iram_addr=BOOT_ADDR.
  - Decode-valid=0, illegal flag=0, writeback valid=0.
  - Register file x1..x31 cleared to 0; x0 reads 0 always.
- Fetch:
  - PC increments by 4 each cycle while not halted.
  - The word on iram_rdata in cycle N belongs to the PC presented in cycle N-1.
  - Decode-valid becomes 1 on the first edge after reset release. iram_rdata is ignored while decode-valid=0.
- Decode/execute (combinational on iram_rdata):
  - Supported instructions: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND; their immediate forms ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI; and LUI.
  - I-immediate is sign-extended. Shift amount is the low 5 bits. LUI result = imm[31:12]<<12.
  - Arithmetic is modulo 2^32 with no overflow trap. SLT compares signed, SLTU compares unsigned.
  - Operand bypass: if writeback is valid, its rd equals rs1/rs2, and rd≠0, use the writeback result instead of the regfile value.
  - Result, rd and write-enable are registered into writeback.
- Writeback: on the rising edge, regfile[rd] <= result if write-enabled and rd≠0. Writes to x0 are discarded.
- Illegal instruction:
  - Cause: any unsupported opcode/funct3/funct7 while decode-valid=1.
  - Sets sticky flag illegal_instr_ro in the decoder instance (decoder_inst). Register file lives in instance regfile_inst as array regfile[0:31].
  - While the flag is set, PC freezes and no further instructions are issued.
  - The instruction already in writeback still retires. The illegal instruction itself never writes.
  - Only reset clears the flag.
- Throughput and latency: 1 instruction/cycle. A result is architecturally visible 3 cycles after its PC is presented.
- Back-to-back dependencies need no stalls, thanks to the bypass.
- Reset mid-operation: all in-flight results are discarded and fetch restarts at BOOT_ADDR.

Test Plan:
- ADDI x1,x0,2; ADD x2,x1,x0; ADD x3,x0,x2; ADD x4,x3,x0; ADDI x5,x0,1; ADD x10,x4,x5; then illegal word 0 -> x1=x2=x3=x4=2, x10=3, illegal_instr_ro=1, PC frozen.
- ADDI x1,x0,-1; SLTU x2,x0,x1; SLT x3,x1,x0; SUB x4,x0,x1 -> x1=32'hFFFFFFFF, x2=1, x3=1, x4=1.
- LUI x6,0x12345; ORI x6,x6,0x678; SRAI x7,x6,4; SLLI x8,x6,4 -> x6=32'h12345678, x7=32'h01234567, x8=32'h23456780.
- ADDI x0,x0,5 followed by ADD x1,x0,x0 -> x0=0, x1=0.
- Assert rstn_i low mid-program for 2 cycles -> all registers 0, iram_addr=0, execution restarts from word 0.
- Data bus check over the whole run -> dram_we=0, dram_stb=0 at all times; an illegal opcode (e.g. LW) asserts illegal_instr_ro and leaves the register file unchanged.
